// File: rtl/ms6205_pkg.sv
// Shared types for the MS6205 display writer: FSM states and the queued write request.
package ms6205_pkg;
  localparam int MS6205_ADDR_W = 8;
  localparam int MS6205_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_WAIT_RDY
  } ms6205_state_t;

  typedef struct packed {
    logic [MS6205_ADDR_W-1:0] addr;
    logic [MS6205_DATA_W-1:0] data;
  } ms6205_req_t;
endpackage

// File: rtl/sync_edge_pulse.sv
// Two-flop synchroniser followed by a rising-edge detector; pulse_o is one Clk cycle wide.
module sync_edge_pulse (
  input  logic Clk,
  input  logic Rst,
  input  logic din_i,
  output logic pulse_o
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;
endmodule

// File: rtl/ms6205_writer.sv
// Bus master for the MS6205 character display: queues (addr, char) writes and sequences
// address strobe, data strobe and ready wait, skipping the address phase on auto-increment.
module ms6205_writer
  import ms6205_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int READY_TIMEOUT = 255
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [MS6205_ADDR_W-1:0] InAddr,
  input  logic [MS6205_DATA_W-1:0] InData,
  input  logic                     Clear,
  output logic [MS6205_ADDR_W-1:0] Address,
  output logic [MS6205_DATA_W-1:0] Data,
  output logic                     WriteAddr,
  output logic                     WriteData,
  input  logic                     DispReady,
  output logic                     Busy,
  output logic                     ErrTimeout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int TW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
  localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(READY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  ms6205_req_t   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  ms6205_req_t   head;

  ms6205_state_t            state_q, state_d;
  logic [SW-1:0]            stb_cnt_q, stb_cnt_d;
  logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
  ms6205_req_t              work_q, work_d;
  logic [MS6205_ADDR_W-1:0] addr_q, addr_d;
  logic [MS6205_DATA_W-1:0] data_q, data_d;
  logic [MS6205_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic                     last_vld_q, last_vld_d;
  logic                     err_q, err_d;
  logic                     rdy_pulse;

  sync_edge_pulse u_rdy_sync (
    .Clk     (Clk),
    .Rst     (Rst),
    .din_i   (DispReady),
    .pulse_o (rdy_pulse)
  );

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];
  // Push is judged on the registered count only, so a full FIFO refuses even while popping.
  assign push  = InValid && !full && !Clear;

  always_ff @(posedge Clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: InAddr, data: InData};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (Clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    stb_cnt_d   = stb_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    work_d      = work_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    err_d       = err_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          work_d = head;
          // Display auto-increments its cursor, so the next cell needs no address phase.
          if (last_vld_q && (head.addr == last_addr_q + 8'd1)) begin
            state_d = ST_D_SETUP;
            data_d  = head.data;
          end else begin
            state_d = ST_A_SETUP;
            addr_d  = head.addr;
          end
        end
      end
      ST_A_SETUP: begin
        state_d   = ST_A_STROBE;
        stb_cnt_d = '0;
      end
      ST_A_STROBE: begin
        if (stb_cnt_q == STB_LAST) begin
          state_d = ST_D_SETUP;
          data_d  = work_q.data;
        end else begin
          stb_cnt_d = stb_cnt_q + SW'(1);
        end
      end
      ST_D_SETUP: begin
        state_d   = ST_D_STROBE;
        stb_cnt_d = '0;
      end
      ST_D_STROBE: begin
        if (stb_cnt_q == STB_LAST) begin
          state_d   = ST_WAIT_RDY;
          tmo_cnt_d = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + SW'(1);
        end
      end
      ST_WAIT_RDY: begin
        if (rdy_pulse) begin
          last_addr_d = work_q.addr;
          last_vld_d  = 1'b1;
          state_d     = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          last_vld_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (Clear) begin
      state_d    = ST_IDLE;
      err_d      = 1'b0;
      last_vld_d = 1'b0;
      pop        = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      stb_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      work_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_cnt_q   <= stb_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      work_q      <= work_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
      err_q       <= err_d;
    end
  end

  assign InReady    = !full;
  assign Address    = addr_q;
  assign Data       = data_q;
  assign WriteAddr  = (state_q == ST_A_STROBE);
  assign WriteData  = (state_q == ST_D_STROBE);
  assign Busy       = !empty || (state_q != ST_IDLE);
  assign ErrTimeout = err_q;
endmodule

// File: tb/tb_ms6205_writer.sv
// Directed self-checking bench for ms6205_writer; inputs driven and outputs sampled on negedge.
module tb_ms6205_writer;
  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [7:0] InAddr = 8'h00;
  logic [7:0] InData = 8'h00;
  logic       Clear = 1'b0;
  logic [7:0] Address;
  logic [7:0] Data;
  logic       WriteAddr, WriteData;
  logic       DispReady = 1'b0;
  logic       Busy, ErrTimeout;

  int checks = 0;
  int errors = 0;
  int wa_cnt = 0;
  int overlap = 0;

  ms6205_writer #(.FIFO_DEPTH(4), .STROBE_CYCLES(2), .READY_TIMEOUT(255)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .InAddr(InAddr),
    .InData(InData), .Clear(Clear), .Address(Address), .Data(Data),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .DispReady(DispReady),
    .Busy(Busy), .ErrTimeout(ErrTimeout)
  );

  always #5 Clk = ~Clk;

  always @(posedge WriteAddr) wa_cnt++;
  always @(negedge Clk) if (WriteAddr && WriteData) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    InAddr  = a;
    InData  = d;
    InValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (InReady) begin
        ok = 1'b1;
        @(negedge Clk);
        break;
      end
      @(negedge Clk);
    end
    InValid = 1'b0;
  endtask

  task automatic wait_wd(input logic lvl, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (WriteData == lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  // Waits for the data strobe to finish, then gives one ready rising edge.
  task automatic serve(output bit ok);
    bit ok1, ok2;
    wait_wd(1'b1, 60, ok1);
    wait_wd(1'b0, 10, ok2);
    ok = ok1 && ok2;
    DispReady = 1'b1;
    repeat (4) @(negedge Clk);
    DispReady = 1'b0;
  endtask

  initial begin
    bit ok;
    int wa0, n;

    // Reset state, then reset asserted in the middle of an address strobe.
    repeat (2) @(negedge Clk);
    check("rst_addr", Address, 8'h00);
    check("rst_data", Data, 8'h00);
    check("rst_wa", WriteAddr, 1'b0);
    check("rst_wd", WriteData, 1'b0);
    check("rst_err", ErrTimeout, 1'b0);
    check("rst_busy", Busy, 1'b0);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_inready", InReady, 1'b1);
    push(8'h05, 8'h31, ok);
    n = 0;
    while (!WriteAddr && n < 10) begin @(negedge Clk); n++; end
    check("t1_wa_seen", WriteAddr, 1'b1);
    #2 Rst = 1'b1;
    #1;
    check("t1_wa_async", WriteAddr, 1'b0);
    check("t1_busy", Busy, 1'b0);
    check("t1_inready", InReady, 1'b1);
    check("t1_addr", Address, 8'h00);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // Single write with exact strobe timing.
    push(8'h10, 8'h41, ok);
    check("t2_push", ok, 1'b1);
    check("t2_busy", Busy, 1'b1);
    @(negedge Clk);
    check("t2_addr_n1", Address, 8'h10);
    check("t2_wa_n1", WriteAddr, 1'b0);
    @(negedge Clk); check("t2_wa_n2", WriteAddr, 1'b1);
    @(negedge Clk); check("t2_wa_n3", WriteAddr, 1'b1);
    @(negedge Clk);
    check("t2_wa_n4", WriteAddr, 1'b0);
    check("t2_wd_n4", WriteData, 1'b0);
    check("t2_data_n4", Data, 8'h41);
    @(negedge Clk); check("t2_wd_n5", WriteData, 1'b1);
    @(negedge Clk); check("t2_wd_n6", WriteData, 1'b1);
    @(negedge Clk);
    check("t2_wd_n7", WriteData, 1'b0);
    check("t2_busy_wait", Busy, 1'b1);
    DispReady = 1'b1;
    n = 0;
    while (Busy && n < 10) begin @(negedge Clk); n++; end
    check("t2_done", Busy, 1'b0);
    DispReady = 1'b0;
    repeat (3) @(negedge Clk);

    // Sequential writes: 0x21 follows 0x20 and skips the address phase.
    wa0 = wa_cnt;
    push(8'h20, 8'h61, ok); serve(ok);
    check("t3_s20", ok, 1'b1);
    check("t3_wa20", wa_cnt - wa0, 1);
    check("t3_idle20", Busy, 1'b0);
    wa0 = wa_cnt;
    push(8'h21, 8'h62, ok); serve(ok);
    check("t3_s21", ok, 1'b1);
    check("t3_wa21", wa_cnt - wa0, 0);
    check("t3_addr21", Address, 8'h20);
    check("t3_data21", Data, 8'h62);
    wa0 = wa_cnt;
    push(8'h23, 8'h63, ok); serve(ok);
    check("t3_wa23", wa_cnt - wa0, 1);
    check("t3_addr23", Address, 8'h23);
    check("t3_idle23", Busy, 1'b0);

    // Five back-to-back requests with the display never ready.
    push(8'h50, 8'h01, ok);
    push(8'h51, 8'h02, ok);
    push(8'h60, 8'h03, ok);
    push(8'h61, 8'h04, ok);
    push(8'h62, 8'h05, ok);
    check("t4_push5", ok, 1'b1);
    check("t4_full", InReady, 1'b0);
    @(negedge Clk);
    check("t4_full2", InReady, 1'b0);
    wait_wd(1'b1, 20, ok);
    check("t4_wd_hi", ok, 1'b1);
    wait_wd(1'b0, 10, ok);
    check("t4_wd_lo", ok, 1'b1);
    n = 0;
    while (!ErrTimeout && n < 400) begin @(negedge Clk); n++; end
    check("t4_tmo_cycles", n, 255);
    check("t4_err", ErrTimeout, 1'b1);
    wa0 = wa_cnt;
    n = 0;
    while (!WriteAddr && n < 10) begin @(negedge Clk); n++; end
    check("t4_next_aphase", wa_cnt - wa0, 1);
    check("t4_next_addr", Address, 8'h51);
    check("t4_inready", InReady, 1'b1);

    // Clear during the data strobe with three requests still queued.
    wait_wd(1'b1, 20, ok);
    check("t5_wd_hi", ok, 1'b1);
    Clear = 1'b1;
    InValid = 1'b1;
    InAddr = 8'h77;
    @(negedge Clk);
    Clear = 1'b0;
    InValid = 1'b0;
    check("t5_wd_drop", WriteData, 1'b0);
    check("t5_busy", Busy, 1'b0);
    check("t5_err", ErrTimeout, 1'b0);
    check("t5_addr_hold", Address, 8'h51);
    check("t5_data_hold", Data, 8'h02);
    repeat (3) @(negedge Clk);
    check("t5_dropped", Busy, 1'b0);
    wa0 = wa_cnt;
    push(8'h52, 8'h11, ok); serve(ok);
    check("t5_aphase52", wa_cnt - wa0, 1);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    wa0 = wa_cnt;
    push(8'h53, 8'h12, ok); serve(ok);
    check("t5_aphase53", wa_cnt - wa0, 1);
    check("t5_idle53", Busy, 1'b0);

    // Ready activity outside WAIT_RDY and sub-cycle glitches.
    wa0 = wa_cnt;
    @(negedge Clk); #1 DispReady = 1'b1; #2 DispReady = 1'b0;
    @(negedge Clk); DispReady = 1'b1;
    repeat (2) @(negedge Clk); DispReady = 1'b0;
    repeat (4) @(negedge Clk);
    check("t6_idle_busy", Busy, 1'b0);
    check("t6_idle_err", ErrTimeout, 1'b0);
    check("t6_idle_wa", wa_cnt - wa0, 0);
    push(8'h54, 8'h13, ok);
    DispReady = 1'b1;
    wait_wd(1'b1, 20, ok);
    wait_wd(1'b0, 10, ok);
    check("t6_wait54", ok, 1'b1);
    repeat (10) @(negedge Clk);
    check("t6_stale_high", Busy, 1'b1);
    DispReady = 1'b0;
    repeat (3) @(negedge Clk);
    #1 DispReady = 1'b1; #2 DispReady = 1'b0;
    repeat (5) @(negedge Clk);
    check("t6_glitch", Busy, 1'b1);
    DispReady = 1'b1;
    repeat (5) @(negedge Clk);
    check("t6_done54", Busy, 1'b0);
    push(8'h55, 8'h14, ok);
    wait_wd(1'b1, 20, ok);
    wait_wd(1'b0, 10, ok);
    repeat (10) @(negedge Clk);
    check("t6_one_per_edge", Busy, 1'b1);
    DispReady = 1'b0;
    repeat (3) @(negedge Clk);
    DispReady = 1'b1;
    repeat (5) @(negedge Clk);
    check("t6_done55", Busy, 1'b0);
    check("t6_skip_both", wa_cnt - wa0, 0);
    check("t6_data55", Data, 8'h14);
    check("t6_err", ErrTimeout, 1'b0);
    DispReady = 1'b0;
    repeat (3) @(negedge Clk);

    check("no_strobe_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
